// File: rtl/framebuffer_arbiter.sv
// framebuffer_arbiter: shares the single-port double-buffered frame RAM
// between the SPI pixel writer and the HUB75 scan reader.
module framebuffer_arbiter #(
  parameter int ADDR_WIDTH = 11,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  pixel_clk,
  input  logic                  n_reset,
  input  logic                  wr_frame_start,
  input  logic                  wr_req,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic                  wr_ack,
  output logic [ADDR_WIDTH:0]   wr_count,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_grant,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  frame_end,
  output logic                  swap_pending,
  output logic                  display_buffer,
  output logic [ADDR_WIDTH:0]   ram_addr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic                  ram_we,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam logic [ADDR_WIDTH:0] LAST_COUNT =
    {1'b0, {ADDR_WIDTH{1'b1}}};
  localparam logic [ADDR_WIDTH:0] ONE_C =
    {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] ONE_P =
    {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic {
    FILLING = 1'b0,
    PENDING = 1'b1
  } fill_t;

  fill_t                 state_q;
  fill_t                 state_d;
  logic [ADDR_WIDTH-1:0] ptr_q;
  logic [ADDR_WIDTH-1:0] ptr_d;
  logic [ADDR_WIDTH:0]   count_d;
  logic                  db_d;
  logic                  pend_d;
  logic                  rd_go;
  logic                  wr_go;
  logic                  swap;

  assign rd_data = ram_rdata;

  // Fill state register.
  always_ff @(posedge pixel_clk or negedge n_reset) begin
    if (!n_reset) state_q <= FILLING;
    else          state_q <= state_d;
  end

  // Arbitration, fill tracking and buffer swap decisions.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    count_d = wr_count;
    db_d    = display_buffer;
    pend_d  = 1'b0;
    swap    = frame_end && swap_pending;
    rd_go   = rd_req && !rd_grant;
    wr_go   = wr_req && !wr_ack && !rd_go
           && !wr_frame_start && (state_q == FILLING);
    unique case (state_q)
      FILLING: begin
        if (wr_frame_start) begin
          ptr_d   = '0;
          count_d = '0;
        end else if (wr_go) begin
          ptr_d   = ptr_q + ONE_P;
          count_d = wr_count + ONE_C;
          if (wr_count == LAST_COUNT) state_d = PENDING;
        end
      end
      PENDING: begin
        pend_d = !swap;
        if (swap) begin
          state_d = FILLING;
          db_d    = !display_buffer;
          ptr_d   = '0;
          count_d = '0;
        end
      end
    endcase
  end

  // Registered outputs, RAM port and pointers.
  always_ff @(posedge pixel_clk or negedge n_reset) begin
    if (!n_reset) begin
      wr_ack         <= 1'b0;
      rd_grant       <= 1'b0;
      rd_valid       <= 1'b0;
      ram_we         <= 1'b0;
      swap_pending   <= 1'b0;
      display_buffer <= 1'b0;
      wr_count       <= '0;
      ptr_q          <= '0;
      ram_addr       <= '0;
      ram_wdata      <= '0;
    end else begin
      wr_ack         <= wr_go;
      rd_grant       <= rd_go;
      rd_valid       <= rd_grant;
      ram_we         <= wr_go;
      swap_pending   <= pend_d;
      display_buffer <= db_d;
      wr_count       <= count_d;
      ptr_q          <= ptr_d;
      unique case (1'b1)
        rd_go: ram_addr <= {display_buffer, rd_addr};
        wr_go: begin
          ram_addr  <= {~display_buffer, ptr_q};
          ram_wdata <= wr_data;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_framebuffer_arbiter.sv
// tb_framebuffer_arbiter: directed stimulus with a queue scoreboard
// checking RAM accesses and read data of framebuffer_arbiter.
module tb_framebuffer_arbiter;
  localparam int AW = 11;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          n_reset = 1'b0;
  logic          wr_frame_start = 1'b0;
  logic          wr_req = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_ack;
  logic [AW:0]   wr_count;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_grant;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          frame_end = 1'b0;
  logic          swap_pending;
  logic          display_buffer;
  logic [AW:0]   ram_addr;
  logic [DW-1:0] ram_wdata;
  logic          ram_we;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  framebuffer_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .pixel_clk(clk),
    .n_reset(n_reset),
    .wr_frame_start(wr_frame_start),
    .wr_req(wr_req),
    .wr_data(wr_data),
    .wr_ack(wr_ack),
    .wr_count(wr_count),
    .rd_req(rd_req),
    .rd_addr(rd_addr),
    .rd_grant(rd_grant),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .frame_end(frame_end),
    .swap_pending(swap_pending),
    .display_buffer(display_buffer),
    .ram_addr(ram_addr),
    .ram_wdata(ram_wdata),
    .ram_we(ram_we),
    .ram_rdata(ram_rdata)
  );

  logic [DW-1:0] ram [0:4095];
  always @(posedge clk) begin
    if (ram_we) ram[ram_addr] <= ram_wdata;
    ram_rdata <= ram[ram_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad = 0;

  logic [AW:0]   q_wa [$];
  logic [DW-1:0] q_wd [$];
  logic [AW:0]   q_ra [$];
  logic [DW-1:0] q_rd [$];
  logic [DW-1:0] shadow [0:4095];
  logic          exp_db = 1'b0;
  logic [AW-1:0] exp_ptr = '0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  logic          prev_rg = 1'b0;
  logic          prev_wa = 1'b0;
  logic [AW:0]   m_a;
  logic [DW-1:0] m_d;

  always @(negedge clk) begin
    if (n_reset) begin
      if (wr_ack) begin
        if (q_wa.size() == 0) check("unexpected_wr_ack", wr_ack, 0);
        else begin
          m_a = q_wa.pop_front();
          m_d = q_wd.pop_front();
          check("wr_addr", ram_addr, m_a);
          check("wr_data", ram_wdata, m_d);
          check("wr_we", ram_we, 1);
          check("wr_back_to_back", prev_wa, 0);
        end
      end
      if (rd_grant) begin
        if (q_ra.size() == 0) check("unexpected_rd_grant", rd_grant, 0);
        else begin
          m_a = q_ra.pop_front();
          check("rd_addr", ram_addr, m_a);
          check("rd_we", ram_we, 0);
          check("rd_back_to_back", prev_rg, 0);
        end
      end
      if (rd_valid) begin
        check("rd_valid_latency", prev_rg, 1);
        if (q_rd.size() == 0) check("unexpected_rd_valid", rd_valid, 0);
        else begin
          m_d = q_rd.pop_front();
          check("rd_data", rd_data, m_d);
        end
      end
    end
    prev_rg <= rd_grant;
    prev_wa <= wr_ack;
  end

  task automatic wr_px(input logic [DW-1:0] d, input bit fe_on_ack);
    logic [AW:0] a;
    bit got;
    a = {~exp_db, exp_ptr};
    q_wa.push_back(a);
    q_wd.push_back(d);
    shadow[a] = d;
    exp_ptr++;
    wr_data = d;
    wr_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (wr_ack) begin
        got = 1'b1;
        wr_req = 1'b0;
        if (fe_on_ack) frame_end = 1'b1;
      end
    end
    if (!got) begin
      check("wr_ack_timeout", wr_ack, 1);
      wr_req = 1'b0;
      void'(q_wa.pop_back());
      void'(q_wd.pop_back());
    end
  endtask

  task automatic rd_px(input logic [AW-1:0] ad, input logic bsel);
    logic [AW:0] a;
    bit got;
    a = {bsel, ad};
    q_ra.push_back(a);
    q_rd.push_back(shadow[a]);
    rd_addr = ad;
    rd_req = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      if (rd_grant) begin
        got = 1'b1;
        rd_req = 1'b0;
      end
    end
    if (!got) begin
      check("rd_grant_timeout", rd_grant, 1);
      rd_req = 1'b0;
      void'(q_ra.pop_back());
      void'(q_rd.pop_back());
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_wr_ack"}, wr_ack, 0);
    check({tag, "_rd_grant"}, rd_grant, 0);
    check({tag, "_rd_valid"}, rd_valid, 0);
    check({tag, "_ram_we"}, ram_we, 0);
    check({tag, "_swap_pending"}, swap_pending, 0);
    check({tag, "_wr_count"}, wr_count, 0);
    check({tag, "_ram_addr"}, ram_addr, 0);
    check({tag, "_ram_wdata"}, ram_wdata, 0);
    check({tag, "_display_buffer"}, display_buffer, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int acks;
    int t0;
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    n_reset = 1'b1;
    exp_db = 1'b0;
    exp_ptr = '0;
    @(posedge clk); #1;

    for (int i = 0; i < 100; i++) wr_px(16'h0100 + 16'(i), 1'b0);
    check("count_100", wr_count, 100);
    wr_frame_start = 1'b1;
    @(posedge clk); #1;
    wr_frame_start = 1'b0;
    exp_ptr = '0;
    check("restart_count", wr_count, 0);

    for (int i = 0; i < 2048; i++) wr_px(16'hF000, 1'b0);
    @(posedge clk); #1;
    check("full_swap_pending", swap_pending, 1);
    check("full_wr_count", wr_count, 2048);
    check("full_db", display_buffer, 0);

    wr_data = 16'hDEAD;
    wr_req = 1'b1;
    acks = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (wr_ack) acks++;
    end
    check("stall_acks", acks, 0);
    wr_frame_start = 1'b1;
    @(posedge clk); #1;
    wr_frame_start = 1'b0;
    check("pend_restart_count", wr_count, 2048);
    check("pend_restart_pending", swap_pending, 1);
    wr_req = 1'b0;

    frame_end = 1'b1;
    @(posedge clk); #1;
    frame_end = 1'b0;
    check("swap_db", display_buffer, 1);
    check("swap_pending_clr", swap_pending, 0);
    check("swap_count", wr_count, 0);
    exp_db = 1'b1;
    exp_ptr = '0;

    t0 = cyc;
    fork
      for (int k = 0; k < 8; k++) rd_px(AW'(k), 1'b1);
      for (int k = 0; k < 8; k++) wr_px(16'h1000 + 16'(k), 1'b0);
    join
    check("contention_cycles", cyc - t0, 16);

    for (int i = 8; i < 2047; i++) wr_px(16'h2000 + 16'(i), 1'b0);
    wr_px(16'h2000 + 16'(2047), 1'b1);
    @(posedge clk); #1;
    frame_end = 1'b0;
    check("boundary_db", display_buffer, 1);
    check("boundary_pending", swap_pending, 1);
    check("boundary_count", wr_count, 2048);

    frame_end = 1'b1;
    rd_px(AW'(5), 1'b1);
    frame_end = 1'b0;
    check("rdswap_db", display_buffer, 0);
    check("rdswap_pending", swap_pending, 0);
    check("rdswap_count", wr_count, 0);
    exp_db = 1'b0;
    exp_ptr = '0;
    rd_px(AW'(5), 1'b0);
    wr_px(16'h3333, 1'b0);

    repeat (2) @(posedge clk);
    #1;
    wr_data = 16'h4444;
    wr_req = 1'b1;
    @(posedge clk); #1;
    check("pre_reset_ack", wr_ack, 1);
    n_reset = 1'b0;
    #1;
    wr_req = 1'b0;
    check_reset("mid");
    @(posedge clk); #1;
    n_reset = 1'b1;
    exp_db = 1'b0;
    exp_ptr = '0;
    @(posedge clk); #1;
    wr_px(16'h5555, 1'b0);

    repeat (4) @(posedge clk);
    #1;
    check("q_wa_empty", q_wa.size(), 0);
    check("q_ra_empty", q_ra.size(), 0);
    check("q_rd_empty", q_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
